// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: requester handshakes and dmem bus shared by dmem_arbiter and its environment
interface dmem_arbiter_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
);
  logic p_req, p_wren, p_gnt, p_rvalid;
  logic [ADDR_W-1:0] p_addr;
  logic [DATA_W-1:0] p_wdata, p_rdata;
  logic d_req, d_wren, d_gnt, d_rvalid;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata, d_rdata;
  logic [ADDR_W-1:0] address_dmem;
  logic [DATA_W-1:0] data, q_dmem;
  logic wren;
  modport slave (
    input p_req, p_wren, p_addr, p_wdata, d_req, d_wren, d_addr, d_wdata, q_dmem,
    output p_gnt, p_rvalid, p_rdata, d_gnt, d_rvalid, d_rdata, address_dmem, data, wren
  );
  modport master (
    output p_req, p_wren, p_addr, p_wdata, d_req, d_wren, d_addr, d_wdata, q_dmem,
    input p_gnt, p_rvalid, p_rdata, d_gnt, d_rvalid, d_rdata, address_dmem, data, wren
  );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port dmem arbiter with drive/return pipeline; define DMEM_ARB_RR_EN for round-robin instead of fixed priority with a starvation limit
module dmem_arbiter #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32,
  parameter int MAX_WAIT = 3
) (
  input logic clock,
  input logic reset,
  dmem_arbiter_if.slave bus
);
  typedef enum logic {LAST_P, LAST_D} owner_t;
  owner_t last, last_nxt;
  logic [3:0] wait_cnt, wait_nxt;
  logic p_acc, d_acc, rd_pend, rd_own, rv_p, rv_d;
  logic [DATA_W-1:0] rdata;
  always_comb begin
`ifdef DMEM_ARB_RR_EN
    d_acc = !reset && bus.d_req && (!bus.p_req || last == LAST_P);
`else
    d_acc = !reset && bus.d_req && (!bus.p_req || wait_cnt == 4'(MAX_WAIT));
`endif
    p_acc = !reset && bus.p_req && !d_acc;
    last_nxt = d_acc ? LAST_D : p_acc ? LAST_P : last;
    wait_nxt = (d_acc || !bus.d_req) ? 4'd0 : wait_cnt == 4'(MAX_WAIT) ? wait_cnt : wait_cnt + 4'd1;
  end
  assign bus.p_gnt = p_acc;
  assign bus.d_gnt = d_acc;
  assign bus.p_rvalid = rv_p;
  assign bus.d_rvalid = rv_d;
  assign bus.p_rdata = rv_p ? rdata : '0;
  assign bus.d_rdata = rv_d ? rdata : '0;
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      last <= LAST_D;
      wait_cnt <= '0;
      bus.wren <= 1'b0;
      bus.address_dmem <= '0;
      bus.data <= '0;
      rd_pend <= 1'b0;
      rd_own <= 1'b0;
      rv_p <= 1'b0;
      rv_d <= 1'b0;
      rdata <= '0;
    end else begin
      last <= last_nxt;
      wait_cnt <= wait_nxt;
      bus.wren <= d_acc ? bus.d_wren : p_acc && bus.p_wren;
      bus.address_dmem <= d_acc ? bus.d_addr : p_acc ? bus.p_addr : '0;
      bus.data <= d_acc ? bus.d_wdata : p_acc ? bus.p_wdata : '0;
      rd_pend <= d_acc ? !bus.d_wren : p_acc && !bus.p_wren;
      rd_own <= d_acc;
      rv_p <= rd_pend && !rd_own;
      rv_d <= rd_pend && rd_own;
      rdata <= rd_pend ? bus.q_dmem : '0;
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: randomized scoreboard bench for dmem_arbiter against a transaction-level reference model
module tb_dmem_arbiter;
  localparam int AW = 12, DW = 32, MAX_WAIT = 3;
  logic clock = 1'b0, reset = 1'b1;
  int cyc = 0, n_checks = 0, n_fail = 0;
  int d_losses = 0;
  bit last_d = 1'b1;
  typedef struct {int cyc; logic wr; logic [AW-1:0] addr; logic [DW-1:0] data;} drv_t;
  typedef struct {int cyc; logic own_d; logic [DW-1:0] data;} ret_t;
  drv_t dq[$];
  ret_t rq[$];
  logic [DW-1:0] mem [2**AW];
  logic [DW-1:0] ref_mem [2**AW];

  dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MAX_WAIT)) dut (.clock(clock), .reset(reset), .bus(bus));

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (bus.wren) mem[bus.address_dmem] <= bus.data;
    bus.q_dmem <= mem[bus.address_dmem];
  end

  task automatic check(input string name, input bit ok, input string got, input string want);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %s, want %s", name, cyc, got, want);
    end
  endtask

  task automatic check_zero(input string name);
    check(name, bus.p_gnt === 1'b0 && bus.d_gnt === 1'b0 && bus.p_rvalid === 1'b0 && bus.d_rvalid === 1'b0 &&
          bus.wren === 1'b0 && bus.address_dmem === '0 && bus.data === '0 && bus.p_rdata === '0 && bus.d_rdata === '0,
          $sformatf("gnt=%b%b rvalid=%b%b wren=%b addr=%h data=%h rdata=%h/%h", bus.p_gnt, bus.d_gnt, bus.p_rvalid,
                    bus.d_rvalid, bus.wren, bus.address_dmem, bus.data, bus.p_rdata, bus.d_rdata), "all zero");
  endtask

  // reference model: arbitration decided from the rules, transfers tracked as timed transactions
  task automatic step(input bit wait_edge, input bit pr, input bit pw, input logic [AW-1:0] pa, input logic [DW-1:0] pd,
                      input bit dr, input bit dw, input logic [AW-1:0] da, input logic [DW-1:0] dd, output int who);
    bit pwin, dwin, w;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    drv_t e;
    ret_t r;
    if (wait_edge) @(negedge clock);
    bus.p_req = pr; bus.p_wren = pw; bus.p_addr = pa; bus.p_wdata = pd;
    bus.d_req = dr; bus.d_wren = dw; bus.d_addr = da; bus.d_wdata = dd;
    #1;
`ifdef DMEM_ARB_RR_EN
    dwin = dr && (!pr || !last_d);
`else
    dwin = dr && (!pr || d_losses >= MAX_WAIT);
`endif
    pwin = pr && !dwin;
    check("grant", bus.p_gnt === pwin && bus.d_gnt === dwin, $sformatf("p_gnt=%b d_gnt=%b", bus.p_gnt, bus.d_gnt),
          $sformatf("p_gnt=%b d_gnt=%b", pwin, dwin));
    d_losses = (dr && !dwin) ? d_losses + 1 : 0;
    if (pwin || dwin) begin
      last_d = dwin;
      w = dwin ? dw : pw;
      a = dwin ? da : pa;
      d = dwin ? dd : pd;
      e.cyc = cyc + 1; e.wr = w; e.addr = a; e.data = d;
      dq.push_back(e);
      if (w) ref_mem[a] = d;
      else begin
        r.cyc = cyc + 2; r.own_d = dwin; r.data = ref_mem[a];
        rq.push_back(r);
      end
    end
    who = dwin ? 2 : pwin ? 1 : 0;
  endtask

  task automatic idle();
    int who;
    step(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0, who);
  endtask

  always @(negedge clock) begin
    drv_t e;
    ret_t r;
    if (!reset) begin
      e.cyc = cyc; e.wr = 1'b0; e.addr = '0; e.data = '0;
      if (dq.size() != 0 && dq[0].cyc == cyc) e = dq.pop_front();
      check("drive", bus.wren === e.wr && bus.address_dmem === e.addr && bus.data === e.data,
            $sformatf("wren=%b addr=%h data=%h", bus.wren, bus.address_dmem, bus.data),
            $sformatf("wren=%b addr=%h data=%h", e.wr, e.addr, e.data));
      check("rdata_idle", (bus.p_rvalid || bus.p_rdata === '0) && (bus.d_rvalid || bus.d_rdata === '0),
            $sformatf("p_rdata=%h d_rdata=%h", bus.p_rdata, bus.d_rdata), "0 when rvalid low");
      if (bus.p_rvalid || bus.d_rvalid) begin
        check("rvalid_expected", rq.size() != 0, $sformatf("p_rvalid=%b d_rvalid=%b", bus.p_rvalid, bus.d_rvalid), "no rvalid");
        if (rq.size() != 0) begin
          r = rq.pop_front();
          check("rvalid", r.cyc == cyc && bus.p_rvalid === !r.own_d && bus.d_rvalid === r.own_d &&
                (r.own_d ? bus.d_rdata : bus.p_rdata) === r.data,
                $sformatf("cyc=%0d p_rvalid=%b d_rvalid=%b p_rdata=%h d_rdata=%h", cyc, bus.p_rvalid, bus.d_rvalid, bus.p_rdata, bus.d_rdata),
                $sformatf("cyc=%0d port=%s data=%h", r.cyc, r.own_d ? "D" : "P", r.data));
        end
      end else if (rq.size() != 0) begin
        check("rvalid_missing", rq[0].cyc > cyc, "no rvalid", $sformatf("rvalid at cycle %0d", rq[0].cyc));
        if (rq[0].cyc <= cyc) r = rq.pop_front();
      end
    end
  end

  initial begin
    int who;
    int seq[$];
    for (int i = 0; i < 2**AW; i++) begin
      mem[i] = '0;
      ref_mem[i] = '0;
    end
    bus.p_req = 1'b1; bus.p_wren = 1'b0; bus.p_addr = '0; bus.p_wdata = '0;
    bus.d_req = 1'b1; bus.d_wren = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
    repeat (2) @(negedge clock);
    #1 check_zero("reset_state");
    @(negedge clock);
    #2 reset = 1'b0;
    d_losses = 0; last_d = 1'b1;
    step(1'b0, 1'b1, 1'b1, 12'h010, 32'hDEADBEEF, 1'b0, 1'b0, '0, '0, who);
    check("first_edge_accept", bus.p_gnt === 1'b1, $sformatf("p_gnt=%b", bus.p_gnt), "p_gnt=1");
    idle();
    step(1'b1, 1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 12'h020, 32'h12345678, who);
    idle();
    step(1'b1, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 12'h020, '0, who);
    idle();
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b1, 1'b1, AW'(12'h040 + i), $urandom(), 1'b1, 1'b1, AW'(12'h080 + i), $urandom(), who);
      seq.push_back(who);
    end
    foreach (seq[i]) begin
`ifdef DMEM_ARB_RR_EN
      check("both_seq", seq[i] == ((i % 2) ? 2 : 1), $sformatf("winner %0d", seq[i]), $sformatf("winner %0d", (i % 2) ? 2 : 1));
`else
      check("both_seq", seq[i] == ((i % 4 == 3) ? 2 : 1), $sformatf("winner %0d", seq[i]), $sformatf("winner %0d", (i % 4 == 3) ? 2 : 1));
`endif
    end
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b1, 1'b0, AW'(12'h040 + i), '0, 1'b0, 1'b0, '0, '0, who);
      check("p_only", who == 1, $sformatf("winner %0d", who), "winner 1");
    end
    repeat (2) idle();
    for (int i = 0; i < 1500; i++)
      step(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), $urandom(),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), $urandom(), who);
    repeat (3) idle();
    step(1'b1, 1'b1, 1'b0, 12'h005, '0, 1'b0, 1'b0, '0, '0, who);
    @(negedge clock);
    #2 reset = 1'b1;
    bus.p_req = 1'b0; bus.d_req = 1'b0;
    #1 check_zero("reset_async");
    dq.delete();
    rq.delete();
    @(negedge clock);
    #2 reset = 1'b0;
    d_losses = 0; last_d = 1'b1;
    step(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0, who);
    repeat (5) idle();
    check("drained", dq.size() == 0 && rq.size() == 0, $sformatf("%0d drives, %0d returns pending", dq.size(), rq.size()), "none pending");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, dmem word-address width.
REQ-002 SHALL have parameter DATA_W, default 32, dmem data width.
REQ-003 SHALL have parameter MAX_WAIT, default 3, legal 1..15: consecutive lost arbitrations tolerated by port D before it is forced to win.
REQ-004 SHALL have port clock  in  1  master clock, rising edge; the single clock of the block.
REQ-005 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-006 SHALL have port p_req  in  1  processor-port request valid.
REQ-007 SHALL have port p_wren  in  1  processor write (1) / read (0).
REQ-008 SHALL have port p_addr  in  ADDR_W  processor address.
REQ-009 SHALL have port p_wdata  in  DATA_W  processor write data.
REQ-010 SHALL have port p_gnt  out  1  processor request accepted this cycle.
REQ-011 SHALL have port p_rvalid  out  1  processor read data valid.
REQ-012 SHALL have port p_rdata  out  DATA_W  processor read data.
REQ-013 SHALL have ports d_req, d_wren, d_addr, d_wdata, d_gnt, d_rvalid, d_rdata, identical in direction, width and meaning to the p_ set, for the loader/DMA requester.
REQ-014 SHALL have port address_dmem  out  ADDR_W  dmem address.
REQ-015 SHALL have port data  out  DATA_W  dmem write data.
REQ-016 SHALL have port wren  out  1  dmem write enable.
REQ-017 SHALL have port q_dmem  in  DATA_W  dmem read data (dmem clocked on ~clock).

Function
REQ-018 SHALL compute x_gnt combinationally from x_req, the other request and the arbitration state; a transfer is accepted at a rising edge where x_req && x_gnt.
REQ-019 SHALL assert at most one of p_gnt/d_gnt per cycle, and never x_gnt without x_req.
REQ-020 SHALL accept one transfer per cycle with no bubbles; a requester may hold req high for back-to-back accepts.
REQ-021 SHALL register the accepted addr/wdata/wren at the accept edge and drive address_dmem, data, wren from those registers in the next cycle (N+1); with no accept, the next cycle drives address_dmem=0, data=0, wren=0.
REQ-022 SHALL, for an accepted read, register q_dmem at the end of cycle N+1 and assert the owner's x_rvalid for exactly one cycle in N+2 with x_rdata holding that value; x_rdata SHALL be 0 when x_rvalid is low.
REQ-023 SHALL never assert x_rvalid for writes, nor for the non-owning port.
REQ-024 SHALL (fixed mode) grant P when p_req, unless d_req is high and wait_cnt == MAX_WAIT, in which case grant D; grant D when d_req and !p_req.
REQ-025 SHALL maintain 4-bit wait_cnt: +1 (saturating at MAX_WAIT) each cycle d_req && !d_gnt; cleared on D accept or when d_req is low.
REQ-026 SHALL keep the two-stage pipeline (drive stage, return stage) independent, so reads and writes from either port interleave freely.

Reset
REQ-027 SHALL, while reset is high, force p_gnt, d_gnt, p_rvalid, d_rvalid, wren to 0, address_dmem, data, p_rdata, d_rdata to 0, wait_cnt to 0, and the round-robin pointer to "last = D".
REQ-028 SHALL discard any in-flight transfer on reset: no wren and no rvalid for it after reset deasserts.
REQ-029 SHALL accept new requests on the first rising edge with reset low.

Configuration
REQ-030 SHALL, when macro DMEM_ARB_RR_EN is defined, replace REQ-024/REQ-025 with round-robin: sole requester wins; on tie the port not accepted most recently wins; pointer updates on every accept; wait_cnt and MAX_WAIT unused.
REQ-031 SHALL, when DMEM_ARB_RR_EN is undefined, use fixed priority with starvation limit (REQ-024/REQ-025).

Verification
REQ-032 SHALL cover: reset asserted mid-run -> all outputs 0 immediately, no later rvalid.
REQ-033 SHALL cover: p_req write addr 0x010 data 0xDEADBEEF accepted at N -> cycle N+1 wren=1, address_dmem=0x010, data=0xDEADBEEF; N+2 wren=0, no rvalid.
REQ-034 SHALL cover: d_req read addr 0x020, dmem holds 0x12345678 -> d_gnt at N, address_dmem=0x020 at N+1, d_rvalid=1, d_rdata=0x12345678 at N+2, p_rvalid=0.
REQ-035 SHALL cover: fixed mode, MAX_WAIT=3, p_req and d_req held high -> accept sequence P,P,P,D,P,P,P,D.
REQ-036 SHALL cover: DMEM_ARB_RR_EN defined, both held high -> P,D,P,D; only p_req high -> P every cycle.
REQ-037 SHALL cover: read accepted at N, reset asserted in N+1 -> wren=0, address_dmem=0, no rvalid in N+2.
